// File: rtl/hwpe_ctrl_regfile_bist.sv
// rtl/hwpe_ctrl_regfile_bist.sv - March C- BIST initiator for the register file test wrapper
module hwpe_ctrl_regfile_bist #(
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = '0,
    parameter int unsigned           CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [ADDR_WIDTH-1:0]    fail_addr,
    output logic [DATA_WIDTH-1:0]    fail_syn,
    output logic [CNT_WIDTH-1:0]     fail_cnt,
    output logic                     bist_en,
    output logic                     csn_t,
    output logic                     wen_t,
    output logic [ADDR_WIDTH-1:0]    a_t,
    output logic [DATA_WIDTH-1:0]    d_t,
    output logic [DATA_WIDTH/8-1:0]  be_t,
    input  logic [DATA_WIDTH-1:0]    q_t
);

    localparam int unsigned           NUM_BYTE = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [DATA_WIDTH-1:0] PAT_B    = PATTERN;
    localparam logic [DATA_WIDTH-1:0] PAT_C    = ~PATTERN;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

    // Elements 0..5: M0 up wB, M1 up rB/wC, M2 up rC/wB,
    // M3 down rB/wC, M4 down rC/wB, M5 down rB.
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                  state_q;

    // Sequencer position: the operation to be issued at the next access edge.
    logic [2:0]              elem_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    ph_q;
    logic                    last_q;

    // Registered interface outputs.
    logic                    csn_t_q;
    logic                    wen_t_q;
    logic [ADDR_WIDTH-1:0]   a_t_q;
    logic [DATA_WIDTH-1:0]   d_t_q;
    logic [NUM_BYTE-1:0]     be_t_q;
    logic                    bist_en_q;
    logic                    busy_q;
    logic                    done_q;

    // Expected word travels with the read (stage 1), then lines up with q_t (stage 2).
    logic [DATA_WIDTH-1:0]   exp_q;
    logic                    cmp_vld_q;
    logic [DATA_WIDTH-1:0]   cmp_exp_q;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q;

    logic                    fail_q;
    logic [ADDR_WIDTH-1:0]   fail_addr_q;
    logic [DATA_WIDTH-1:0]   fail_syn_q;
    logic [CNT_WIDTH-1:0]    fail_cnt_q;

    logic                    launch;
    logic                    issue;
    logic [2:0]              cur_elem;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    cur_ph;
    logic                    cur_two;
    logic                    cur_rd;
    logic                    cur_up;
    logic                    cur_ph_last;
    logic                    cur_addr_end;
    logic                    cur_last;
    logic [DATA_WIDTH-1:0]   cur_exp;
    logic [DATA_WIDTH-1:0]   cur_wdata;
    logic [2:0]              elem_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    ph_d;
    logic                    mismatch;
    logic [DATA_WIDTH-1:0]   syndrome;

    // Decode the operation to issue this edge and the sequencer position after it.
    // A launch issues the very first access in the same edge, so the position is
    // forced to element 0 / address 0 regardless of what the counters hold.
    always_comb begin
        launch       = start && (state_q == S_IDLE || state_q == S_DONE);
        issue        = launch || (state_q == S_RUN && !last_q);
        cur_elem     = launch ? 3'd0 : elem_q;
        cur_addr     = launch ? '0   : addr_q;
        cur_ph       = launch ? 1'b0 : ph_q;
        cur_two      = (cur_elem != 3'd0) && (cur_elem != 3'd5);
        cur_rd       = cur_two ? !cur_ph : (cur_elem == 3'd5);
        cur_up       = (cur_elem <= 3'd2);
        cur_exp      = (cur_elem == 3'd2 || cur_elem == 3'd4) ? PAT_C : PAT_B;
        cur_wdata    = (cur_elem == 3'd1 || cur_elem == 3'd3) ? PAT_C : PAT_B;
        cur_ph_last  = !cur_two || cur_ph;
        cur_addr_end = cur_up ? (cur_addr == ADDR_MAX) : (cur_addr == '0);
        cur_last     = (cur_elem == 3'd5) && (cur_addr == '0);

        elem_d = cur_elem;
        addr_d = cur_addr;
        ph_d   = 1'b0;
        if (!cur_ph_last) begin
            ph_d = 1'b1;
        end else if (cur_addr_end) begin
            // Element switch: next element starts at its own end of the array.
            elem_d = cur_elem + 3'd1;
            addr_d = (cur_elem <= 3'd1) ? '0 : ADDR_MAX;
        end else begin
            addr_d = cur_up ? cur_addr + ADDR_WIDTH'(1) : cur_addr - ADDR_WIDTH'(1);
        end
    end

    // Read-data comparison against the pipelined expected word.
    always_comb begin
        syndrome = q_t ^ cmp_exp_q;
        mismatch = cmp_vld_q && (q_t != cmp_exp_q);
    end

    // Controller FSM: access issue, compare pipeline, result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            ph_q        <= 1'b0;
            last_q      <= 1'b0;
            csn_t_q     <= 1'b1;
            wen_t_q     <= 1'b1;
            a_t_q       <= '0;
            d_t_q       <= '0;
            be_t_q      <= '0;
            bist_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exp_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_syn_q  <= '0;
            fail_cnt_q  <= '0;
        end else if (clear) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            ph_q        <= 1'b0;
            last_q      <= 1'b0;
            csn_t_q     <= 1'b1;
            wen_t_q     <= 1'b1;
            a_t_q       <= '0;
            d_t_q       <= '0;
            be_t_q      <= '0;
            bist_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exp_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_syn_q  <= '0;
            fail_cnt_q  <= '0;
        end else begin
            // Stage 2 of the compare pipeline: a read visible last cycle returns data now.
            cmp_vld_q  <= !csn_t_q && wen_t_q;
            cmp_exp_q  <= exp_q;
            cmp_addr_q <= a_t_q;

            if (mismatch) begin
                fail_q <= 1'b1;
                if (!fail_q) begin
                    fail_addr_q <= cmp_addr_q;
                    fail_syn_q  <= syndrome;
                end
                if (fail_cnt_q != CNT_MAX) begin
                    fail_cnt_q <= fail_cnt_q + CNT_WIDTH'(1);
                end
            end

            // One access per edge while the sequence has operations left.
            if (issue) begin
                csn_t_q <= 1'b0;
                wen_t_q <= cur_rd;
                a_t_q   <= cur_addr;
                be_t_q  <= '1;
                exp_q   <= cur_exp;
                if (!cur_rd) begin
                    d_t_q <= cur_wdata;
                end
                elem_q  <= elem_d;
                addr_q  <= addr_d;
                ph_q    <= ph_d;
                last_q  <= cur_last;
            end else begin
                csn_t_q <= 1'b1;
                wen_t_q <= 1'b1;
                be_t_q  <= '0;
            end

            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state_q     <= S_RUN;
                        busy_q      <= 1'b1;
                        bist_en_q   <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_syn_q  <= '0;
                        fail_cnt_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (last_q) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The final read is compared this cycle; results are complete next.
                    state_q   <= S_DONE;
                    busy_q    <= 1'b0;
                    bist_en_q <= 1'b0;
                    done_q    <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_syn  = fail_syn_q;
    assign fail_cnt  = fail_cnt_q;
    assign bist_en   = bist_en_q;
    assign csn_t     = csn_t_q;
    assign wen_t     = wen_t_q;
    assign a_t       = a_t_q;
    assign d_t       = d_t_q;
    assign be_t      = be_t_q;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist.sv
// tb/tb_hwpe_ctrl_regfile_bist.sv - self-checking bench for the March C- BIST initiator
module tb_hwpe_ctrl_regfile_bist;

    localparam int N    = 32;
    localparam int NOPS = 10 * N;
    localparam int N2   = 64;
    localparam logic [31:0] PB = 32'h0000_0000;
    localparam logic [31:0] PC = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, clear, start, start2;
    logic        busy, done, fail, bist_en, csn_t, wen_t;
    logic [4:0]  fail_addr, a_t;
    logic [31:0] fail_syn, d_t;
    logic [31:0] q_t = 32'h0;
    logic [7:0]  fail_cnt;
    logic [3:0]  be_t;

    logic        busy2, done2, fail2, bist_en2, csn_t2, wen_t2;
    logic [5:0]  fail_addr2, a_t2;
    logic [31:0] fail_syn2, d_t2;
    logic [31:0] q_t2;
    logic [7:0]  fail_cnt2;
    logic [3:0]  be_t2;

    always #5 clk = ~clk;

    hwpe_ctrl_regfile_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .PATTERN(32'h0), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_syn(fail_syn), .fail_cnt(fail_cnt), .bist_en(bist_en),
        .csn_t(csn_t), .wen_t(wen_t), .a_t(a_t), .d_t(d_t), .be_t(be_t), .q_t(q_t)
    );

    // Larger array so that every-read-fails exceeds the 8-bit counter range.
    hwpe_ctrl_regfile_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .PATTERN(32'h0), .CNT_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .start(start2),
        .busy(busy2), .done(done2), .fail(fail2), .fail_addr(fail_addr2),
        .fail_syn(fail_syn2), .fail_cnt(fail_cnt2), .bist_en(bist_en2),
        .csn_t(csn_t2), .wen_t(wen_t2), .a_t(a_t2), .d_t(d_t2), .be_t(be_t2), .q_t(q_t2)
    );

    assign q_t2 = 32'h0F0F_0F0F;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Fault configuration: 0 none, 1 stuck-at bit, 2 write-to-aggressor flips victim bit.
    int fault_kind = 0;
    int f_addr = 0, f_bit = 0, c_agg = 0, c_vic = 1;
    bit f_val = 1'b0;

    function automatic logic [31:0] faulty_read(input int a, input logic [31:0] v);
        logic [31:0] m;
        m = 32'h1 << f_bit;
        if (fault_kind == 1 && a == f_addr) return f_val ? (v | m) : (v & ~m);
        return v;
    endfunction

    logic [31:0] mem [N];

    // Register file behind the BIST port: synchronous, read data one cycle later.
    always @(posedge clk) begin
        if (!csn_t) begin
            if (!wen_t) begin
                mem[a_t] <= d_t;
                if (fault_kind == 2 && int'(a_t) == c_agg) mem[c_vic] <= mem[c_vic] ^ (32'h1 << f_bit);
            end else begin
                q_t <= faulty_read(int'(a_t), mem[a_t]);
            end
        end
    end

    typedef struct {
        bit          wr;
        int          addr;
        logic [31:0] data;
    } op_t;

    op_t ops[$];

    task automatic push_op(input bit wr, input int a, input logic [31:0] d);
        op_t o;
        o.wr = wr; o.addr = a; o.data = d;
        ops.push_back(o);
    endtask

    // March C- access list straight from the element definitions.
    task automatic build_ops();
        int a;
        ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = (e < 3) ? i : N - 1 - i;
                case (e)
                    0: push_op(1, a, PB);
                    1: begin push_op(0, a, PB); push_op(1, a, PC); end
                    2: begin push_op(0, a, PC); push_op(1, a, PB); end
                    3: begin push_op(0, a, PB); push_op(1, a, PC); end
                    4: begin push_op(0, a, PC); push_op(1, a, PB); end
                    default: push_op(0, a, PB);
                endcase
            end
        end
    endtask

    bit          e_fail;
    int          e_cnt, e_addr;
    logic [31:0] e_syn;

    // Replays the access list on an ideal array with the configured fault.
    task automatic model_run();
        logic [31:0] m [N];
        logic [31:0] q;
        for (int i = 0; i < N; i++) m[i] = 32'h0;
        e_fail = 0; e_cnt = 0; e_addr = 0; e_syn = 32'h0;
        foreach (ops[i]) begin
            if (ops[i].wr) begin
                m[ops[i].addr] = ops[i].data;
                if (fault_kind == 2 && ops[i].addr == c_agg) m[c_vic] = m[c_vic] ^ (32'h1 << f_bit);
            end else begin
                q = faulty_read(ops[i].addr, m[ops[i].addr]);
                if (q !== ops[i].data) begin
                    if (!e_fail) begin e_addr = ops[i].addr; e_syn = q ^ ops[i].data; end
                    e_fail = 1;
                    if (e_cnt < 255) e_cnt++;
                end
            end
        end
    endtask

    int cyc = 0;
    int run_s = 0;
    bit mon_on = 0;
    int mon_k;
    op_t mo;
    logic [63:0] act_v, exp_v;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare of the BIST port and status against the access list.
    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            mon_k = cyc - run_s + 1;
            if (mon_k >= 1 && mon_k <= NOPS) begin
                mo    = ops[mon_k - 1];
                act_v = {15'h0, csn_t, wen_t, bist_en, busy, done, be_t, 3'b0, a_t, (wen_t ? 32'h0 : d_t)};
                exp_v = {15'h0, 1'b0, !mo.wr, 1'b1, 1'b1, 1'b0, 4'hF, 3'b0, 5'(mo.addr), (mo.wr ? mo.data : 32'h0)};
                chk("access", act_v, exp_v);
            end else if (mon_k == NOPS + 1) begin
                chk("drain", {59'h0, csn_t, wen_t, bist_en, busy, done}, {59'h0, 5'b11110});
                chk("drain_be", {60'h0, be_t}, 64'h0);
            end else if (mon_k == NOPS + 2) begin
                chk("done_state", {55'h0, csn_t, wen_t, bist_en, busy, done, be_t}, {55'h0, 5'b11001, 4'h0});
                chk("result", {18'h0, fail, fail_addr, fail_cnt, fail_syn},
                              {18'h0, e_fail, 5'(e_addr), 8'(e_cnt), e_syn});
            end
        end
    end

    int drv_k;
    bit got_done;

    // One full test run; optional stray start pulses while busy.
    task automatic do_run(input bit rnd_pulses, input bit fixed_pulses);
        model_run();
        @(negedge clk);
        start = 1; run_s = cyc + 1; mon_on = 1;
        got_done = 0; drv_k = 0;
        for (int i = 0; i < NOPS + 20; i++) begin
            @(negedge clk);
            drv_k = cyc - run_s + 1;
            if (done) begin got_done = 1; break; end
            start = 0;
            if (busy && fixed_pulses && (drv_k == 50 || drv_k == 200)) start = 1;
            if (busy && rnd_pulses && $urandom_range(0, 29) == 0) start = 1;
        end
        start = 0; mon_on = 0;
        chk("done_latency", got_done ? drv_k : -1, NOPS + 2);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ctl"}, {36'h0, csn_t, wen_t, bist_en, busy, done, fail, be_t, a_t, fail_addr, fail_cnt},
                          {36'h0, 6'b110000, 4'h0, 5'h0, 5'h0, 8'h0});
        chk({nm, "_data"}, {d_t, fail_syn}, 64'h0);
    endtask

    // Abort a run part-way with either async reset or sync clear.
    task automatic abort_run(input bit use_rst, input int at_k);
        @(negedge clk);
        start = 1; run_s = cyc + 1;
        @(negedge clk);
        start = 0;
        repeat (at_k - 1) @(negedge clk);
        if (use_rst) begin
            rst = 1;
            #1;
            chk_reset("abort_rst");
            @(negedge clk);
            rst = 0;
        end else begin
            clear = 1;
            @(posedge clk);
            #1;
            chk_reset("abort_clr");
            @(negedge clk);
            clear = 0;
        end
    endtask

    int s2, k2;

    initial begin
        rst = 1; clear = 0; start = 0; start2 = 0;
        build_ops();
        chk("model_len", ops.size(), NOPS);
        chk("model_m0_31", {ops[31].wr, 32'(ops[31].addr)}, {1'b1, 32'd31});
        chk("model_m3_first", {ops[160].wr, 32'(ops[160].addr), ops[161].wr, ops[161].data}, {1'b0, 32'd31, 1'b1, PC});
        chk("model_last", {ops[NOPS-1].wr, 32'(ops[NOPS-1].addr)}, {1'b0, 32'd0});

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 0;
        @(negedge clk);
        chk_reset("idle");

        // Fault-free, with start pulses at cycles 50 and 200 that must be ignored.
        fault_kind = 0;
        do_run(0, 1);
        chk("ff_fail", {fail, fail_cnt}, 9'h0);

        // Stuck-at-1 on bit 3 of address 5.
        fault_kind = 1; f_addr = 5; f_bit = 3; f_val = 1;
        do_run(0, 0);
        chk("sa1_lit", {fail, fail_addr, fail_syn, fail_cnt}, {1'b1, 5'd5, 32'h8, 8'd3});

        // Write to 7 flips bit 0 of 9.
        fault_kind = 2; c_agg = 7; c_vic = 9; f_bit = 0;
        do_run(0, 0);
        chk("cf_lit", {fail, fail_addr, fail_syn}, {1'b1, 5'd9, 32'h1});

        // Async reset at cycle 100, then a complete run from IDLE.
        fault_kind = 0;
        abort_run(1, 100);
        do_run(0, 0);

        // Sync clear at cycle 60, then a complete run from IDLE.
        abort_run(0, 60);
        do_run(1, 0);

        // Randomized fault placements, restarts straight out of DONE.
        for (int r = 0; r < 8; r++) begin
            fault_kind = $urandom_range(0, 2);
            f_addr     = $urandom_range(0, N - 1);
            f_bit      = $urandom_range(0, 31);
            f_val      = 1'($urandom_range(0, 1));
            c_agg      = $urandom_range(0, N - 1);
            c_vic      = (c_agg + $urandom_range(1, N - 1)) % N;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run(1, 0);
        end

        // Every read wrong on the 64-word instance: counter saturates.
        @(negedge clk);
        start2 = 1; s2 = cyc + 1;
        @(negedge clk);
        start2 = 0;
        k2 = -1;
        for (int i = 0; i < 10 * N2 + 20; i++) begin
            if (done2) begin k2 = cyc - s2 + 1; break; end
            @(negedge clk);
        end
        chk("sat_latency", k2, 10 * N2 + 2);
        chk("sat_result", {fail2, fail_addr2, fail_syn2, fail_cnt2}, {1'b1, 6'd0, 32'h0F0F_0F0F, 8'd255});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
